// File: rtl/xc_malu_pkg.sv
// Shared constants and helpers for the XCrypto multiply/divide ALU.
// Lane-width decoding is common to the datapath and the result unpacking.
package xc_malu_pkg;

    localparam int XLEN       = 32;
    localparam int ITERATIONS = 32;

    localparam int PW_32 = 0;
    localparam int PW_16 = 1;
    localparam int PW_8  = 2;
    localparam int PW_4  = 3;
    localparam int PW_2  = 4;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MUL,
        OP_PMUL,
        OP_DIV,
        OP_REM,
        OP_MACC,
        OP_MADD,
        OP_MSUB
    } op_t;

    // log2 of the packed lane width selected by the one-hot pw field
    function automatic logic [2:0] lane_log2(input logic [4:0] pw);
        logic [2:0] lg;
        lg = 3'd5;
        if (pw[PW_32])      lg = 3'd5;
        else if (pw[PW_16]) lg = 3'd4;
        else if (pw[PW_8])  lg = 3'd3;
        else if (pw[PW_4])  lg = 3'd2;
        else if (pw[PW_2])  lg = 3'd1;
        return lg;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [4:0] idx, input logic [2:0] lg);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < XLEN; b++) begin
            mask[b] = ((5'(b) >> lg) == (idx >> lg));
        end
        return mask;
    endfunction

endpackage

// File: rtl/xc_malu_muldiv.sv
// Shared one-bit-per-cycle shift-add multiplier / restoring divider.
// XC_MALU_CARRYLESS_EN adds the XOR (GF(2)) accumulate path.
module xc_malu_muldiv
    import xc_malu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    input  logic [4:0]  index,
    input  logic        div_mode,
    input  logic        packed_mode,
    input  logic        clmul,
    input  logic        sub_msb,
    input  logic [2:0]  lane_lg,
    input  logic [63:0] opa,
    input  logic [31:0] opb,
    output logic [63:0] acc
);

    logic [63:0] masked;
    logic [63:0] addend;
    logic [63:0] mul_next;
    logic [63:0] div_next;
    logic [31:0] dividend;
    logic [32:0] part_rem;
    logic [33:0] diff;

    // Packed lanes: only the active lane of rs1 is added, shifted into its own
    // 2w-wide product field; a lane product never exceeds its field, so no carry leaks.
    always_comb begin
        masked   = packed_mode ? {32'b0, opa[31:0] & lane_mask(index, lane_lg)} : opa;
        addend   = masked << index;
        mul_next = acc;
        if (opb[index]) begin
`ifdef XC_MALU_CARRYLESS_EN
            if (clmul)
                mul_next = acc ^ addend;
            else
`endif
            if (sub_msb && index == 5'd31)
                mul_next = acc - addend;
            else
                mul_next = acc + addend;
        end
        dividend = opa[31:0];
        part_rem = {acc[63:32], dividend[5'd31 - index]};
        diff     = {1'b0, part_rem} - {2'b0, opb};
        div_next = diff[33] ? {part_rem[31:0], acc[30:0], 1'b0}
                            : {diff[31:0], acc[30:0], 1'b1};
    end

`ifndef XC_MALU_CARRYLESS_EN
    logic unused_clmul;
    assign unused_clmul = clmul;
`endif

    always_ff @(posedge clock) begin
        if (reset || clear)
            acc <= '0;
        else if (step)
            acc <= div_mode ? div_next : mul_next;
    end

endmodule

// File: rtl/xc_malu_core.sv
// XCrypto multi-cycle multiply/divide ALU: operand signs, 3-operand adder, handshake.
// Define XC_MALU_CARRYLESS_EN to honour the carryless flag for mul/pmul.
module xc_malu_core
    import xc_malu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] rs3,
    input  logic        valid,
    input  logic        flush,
    output logic        ready,
    input  logic        insn_mul,
    input  logic        insn_pmul,
    input  logic        insn_div,
    input  logic        insn_rem,
    input  logic        insn_macc,
    input  logic        insn_madd,
    input  logic        insn_msub,
    input  logic [4:0]  pw,
    input  logic        lhs_sign,
    input  logic        rhs_sign,
    input  logic        drem_unsigned,
    input  logic        carryless,
    output logic [31:0] result_1,
    output logic [31:0] result_0
);

    op_t         op;
    logic [5:0]  count;
    logic        iterative;
    logic        done;
    logic        step;
    logic        clear;
    logic        clmul;
    logic        div_mode;
    logic        neg1;
    logic        neg2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [63:0] mul_a;
    logic [63:0] opa;
    logic [31:0] opb;
    logic [2:0]  lane_lg;
    logic [63:0] acc;
    logic [63:0] res;
    logic [31:0] packed_lo;
    logic [31:0] packed_hi;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [5:0]  lo_idx;

`ifdef XC_MALU_CARRYLESS_EN
    assign clmul = carryless;
`else
    logic unused_carryless;
    assign unused_carryless = carryless;
    assign clmul = 1'b0;
`endif

    always_comb begin
        op = OP_NONE;
        if (insn_mul)       op = OP_MUL;
        else if (insn_pmul) op = OP_PMUL;
        else if (insn_div)  op = OP_DIV;
        else if (insn_rem)  op = OP_REM;
        else if (insn_macc) op = OP_MACC;
        else if (insn_madd) op = OP_MADD;
        else if (insn_msub) op = OP_MSUB;
    end

    assign iterative = op inside {OP_MUL, OP_PMUL, OP_DIV, OP_REM};
    assign div_mode  = op inside {OP_DIV, OP_REM};
    assign done      = (count == 6'(ITERATIONS));
    assign clear     = flush || !valid;
    assign step      = valid && !flush && iterative && !done;
    assign ready     = !reset && valid && (iterative ? done : (op != OP_NONE));

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (step)
            count <= count + 6'd1;
    end

    // Division runs on magnitudes; signs are restored on the way out
    assign neg1    = !drem_unsigned && rs1[31];
    assign neg2    = !drem_unsigned && rs2[31];
    assign mag1    = neg1 ? 32'd0 - rs1 : rs1;
    assign mag2    = neg2 ? 32'd0 - rs2 : rs2;
    assign mul_a   = (op == OP_MUL && lhs_sign && !clmul) ? {{32{rs1[31]}}, rs1} : {32'b0, rs1};
    assign opa     = div_mode ? {32'b0, mag1} : mul_a;
    assign opb     = div_mode ? mag2 : rs2;
    assign lane_lg = lane_log2(pw);

    xc_malu_muldiv u_muldiv (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .step        (step),
        .index       (count[4:0]),
        .div_mode    (div_mode),
        .packed_mode (op == OP_PMUL),
        .clmul       (clmul),
        .sub_msb     (op == OP_MUL && rhs_sign && !clmul),
        .lane_lg     (lane_lg),
        .opa         (opa),
        .opb         (opb),
        .acc         (acc)
    );

    // Lane k's 2w-bit product sits at acc[2wk +: 2w]; split it into low/high halves
    always_comb begin
        packed_lo = '0;
        packed_hi = '0;
        lo_idx    = '0;
        for (int b = 0; b < XLEN; b++) begin
            lo_idx       = 6'(((b >> lane_lg) << (lane_lg + 1)) + (b & ((1 << lane_lg) - 1)));
            packed_lo[b] = acc[lo_idx];
            packed_hi[b] = acc[lo_idx + 6'(1 << lane_lg)];
        end
        quot = (neg1 ^ neg2) ? 32'd0 - acc[31:0] : acc[31:0];
        rem  = neg1 ? 32'd0 - acc[63:32] : acc[63:32];
        if (rs2 == 32'd0) begin
            quot = 32'hFFFF_FFFF;
            rem  = rs1;
        end
        case (op)
            OP_PMUL: res = {packed_hi, packed_lo};
            OP_DIV:  res = {32'b0, quot};
            OP_REM:  res = {32'b0, rem};
            OP_MACC: res = {rs2, rs1} + {32'b0, rs3};
            OP_MADD: res = {32'b0, rs1} + {32'b0, rs2} + {32'b0, rs3};
            OP_MSUB: res = {32'b0, rs1} - {32'b0, rs2} - {32'b0, rs3};
            default: res = acc;
        endcase
    end

    assign result_1 = res[63:32];
    assign result_0 = res[31:0];

endmodule

// File: tb/tb_xc_malu_core.sv
// Self-checking bench for xc_malu_core: directed corner cases plus random
// regression against a plain-arithmetic 64-bit reference model.
module tb_xc_malu_core;

    localparam int OP_MUL  = 0;
    localparam int OP_PMUL = 1;
    localparam int OP_DIV  = 2;
    localparam int OP_REM  = 3;
    localparam int OP_MACC = 4;
    localparam int OP_MADD = 5;
    localparam int OP_MSUB = 6;

`ifdef XC_MALU_CARRYLESS_EN
    localparam bit CL_EN = 1'b1;
`else
    localparam bit CL_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rs1, rs2, rs3;
    logic        valid, flush, ready;
    logic        insn_mul, insn_pmul, insn_div, insn_rem, insn_macc, insn_madd, insn_msub;
    logic [4:0]  pw;
    logic        lhs_sign, rhs_sign, drem_unsigned, carryless;
    logic [31:0] result_1, result_0;

    int checks = 0;
    int errors = 0;
    int cyc;

    xc_malu_core dut (
        .clock         (clock),
        .reset         (reset),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs3           (rs3),
        .valid         (valid),
        .flush         (flush),
        .ready         (ready),
        .insn_mul      (insn_mul),
        .insn_pmul     (insn_pmul),
        .insn_div      (insn_div),
        .insn_rem      (insn_rem),
        .insn_macc     (insn_macc),
        .insn_madd     (insn_madd),
        .insn_msub     (insn_msub),
        .pw            (pw),
        .lhs_sign      (lhs_sign),
        .rhs_sign      (rhs_sign),
        .drem_unsigned (drem_unsigned),
        .carryless     (carryless),
        .result_1      (result_1),
        .result_0      (result_0)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] clmulRef(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (b[i]) r = r ^ (a << i);
        return r;
    endfunction

    function automatic logic [63:0] refModel(input int op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [4:0] pwv,
                                             input logic ls, input logic rsn, input logic du,
                                             input logic cl);
        logic [63:0] r, ea, eb, mask, x, y, p;
        logic [31:0] q, rm;
        logic        use_cl;
        int          w;
        use_cl = cl && CL_EN;
        r = '0;
        case (op)
            OP_MUL: begin
                if (use_cl) begin
                    r = clmulRef({32'b0, a}, {32'b0, b});
                end else begin
                    ea = ls  ? {{32{a[31]}}, a} : {32'b0, a};
                    eb = rsn ? {{32{b[31]}}, b} : {32'b0, b};
                    r  = ea * eb;
                end
            end
            OP_PMUL: begin
                w = pwv[0] ? 32 : pwv[1] ? 16 : pwv[2] ? 8 : pwv[3] ? 4 : 2;
                mask = (64'd1 << w) - 64'd1;
                for (int k = 0; k < 32 / w; k++) begin
                    x = ({32'b0, a} >> (w * k)) & mask;
                    y = ({32'b0, b} >> (w * k)) & mask;
                    p = use_cl ? clmulRef(x, y) : x * y;
                    r[31:0]  = r[31:0]  | 32'((p & mask) << (w * k));
                    r[63:32] = r[63:32] | 32'(((p >> w) & mask) << (w * k));
                end
            end
            OP_DIV, OP_REM: begin
                if (b == 32'd0) begin
                    q = 32'hFFFF_FFFF;
                    rm = a;
                end else if (du) begin
                    q = a / b;
                    rm = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    rm = 32'd0;
                end else begin
                    q = 32'($signed(a) / $signed(b));
                    rm = 32'($signed(a) % $signed(b));
                end
                r = {32'b0, (op == OP_DIV) ? q : rm};
            end
            OP_MACC: r = {b, a} + {32'b0, c};
            OP_MADD: r = {32'b0, a} + {32'b0, b} + {32'b0, c};
            OP_MSUB: r = {32'b0, a} - {32'b0, b} - {32'b0, c};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clearInsn();
        insn_mul = 0; insn_pmul = 0; insn_div = 0; insn_rem = 0;
        insn_macc = 0; insn_madd = 0; insn_msub = 0;
    endtask

    // Issue one request, wait for ready (bounded), check latency and result, then flush
    task automatic applyStimulus(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [4:0] pwv, input logic ls,
                                 input logic rsn, input logic du, input logic cl, input string tag);
        logic [63:0] expv;
        int          lat;
        int          n;
        insn_mul  = (op == OP_MUL);
        insn_pmul = (op == OP_PMUL);
        insn_div  = (op == OP_DIV);
        insn_rem  = (op == OP_REM);
        insn_macc = (op == OP_MACC);
        insn_madd = (op == OP_MADD);
        insn_msub = (op == OP_MSUB);
        rs1 = a; rs2 = b; rs3 = c; pw = pwv;
        lhs_sign = ls; rhs_sign = rsn; drem_unsigned = du; carryless = cl;
        valid = 1'b1;
        flush = 1'b0;
        expv = refModel(op, a, b, c, pwv, ls, rsn, du, cl);
        lat  = (op >= OP_MACC) ? 1 : 33;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ready && n < 40);
        checkOutput({tag, "_latency"}, 64'(n), 64'(lat));
        checkOutput({tag, "_result"}, {result_1, result_0}, expv);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        clearInsn();
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; flush = 1'b0;
        rs1 = '0; rs2 = '0; rs3 = '0; pw = 5'b00001;
        lhs_sign = 0; rhs_sign = 0; drem_unsigned = 0; carryless = 0;
        clearInsn();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_ready", 64'(ready), 64'd0);
        checkOutput("reset_result", {result_1, result_0}, 64'd0);
        @(posedge clock);
        #1;

        applyStimulus(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5'b00001, 0, 0, 0, 0, "mul_uu_max");
        applyStimulus(OP_MUL,  32'hFFFF_FFFF, 32'h0000_0002, 0, 5'b00001, 1, 1, 0, 0, "mul_ss");
        applyStimulus(OP_MUL,  32'h8000_0000, 32'hFFFF_FFFF, 0, 5'b00001, 1, 0, 0, 0, "mul_su");
        applyStimulus(OP_MUL,  32'hFFFF_FFFF, 32'h8000_0000, 0, 5'b00001, 0, 1, 0, 0, "mul_us");
        applyStimulus(OP_MUL,  32'h0000_0003, 32'h0000_0003, 0, 5'b00001, 0, 0, 0, 1, "clmul_3x3");
        applyStimulus(OP_PMUL, 32'h0003_FFFF, 32'h0005_FFFF, 0, 5'b00010, 0, 0, 0, 0, "pmul16");
        applyStimulus(OP_PMUL, 32'hFF12_34F0, 32'h80FF_0A07, 0, 5'b00100, 0, 0, 0, 0, "pmul8");
        applyStimulus(OP_PMUL, 32'hF0F0_ABCD, 32'hFFFF_1234, 0, 5'b01000, 0, 0, 0, 0, "pmul4");
        applyStimulus(OP_PMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5'b10000, 0, 0, 0, 0, "pmul2");
        applyStimulus(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 5'b00001, 0, 0, 0, 0, "div_ovf");
        applyStimulus(OP_DIV,  32'h1234_5678, 32'h0000_0000, 0, 5'b00001, 0, 0, 1, 0, "div_zero_u");
        applyStimulus(OP_DIV,  32'hF234_5678, 32'h0000_0000, 0, 5'b00001, 0, 0, 0, 0, "div_zero_s");
        applyStimulus(OP_REM,  32'h0000_0007, 32'h0000_0000, 0, 5'b00001, 0, 0, 1, 0, "rem_zero");
        applyStimulus(OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 0, 5'b00001, 0, 0, 0, 0, "rem_neg");
        applyStimulus(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 5'b00001, 0, 0, 0, 0, "rem_ovf");
        applyStimulus(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 0, 5'b00001, 0, 0, 0, 0, "div_neg");
        applyStimulus(OP_MADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 5'b00001, 0, 0, 0, 0, "madd_carry");
        applyStimulus(OP_MACC, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 5'b00001, 0, 0, 0, 0, "macc_carry");
        applyStimulus(OP_MSUB, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 5'b00001, 0, 0, 0, 0, "msub_borrow");
        repeat (2) @(posedge clock);
        #1;

        // Reset in cycle 10 of a divide must abort it; the restarted request takes a full 33 cycles
        insn_div = 1; rs1 = 32'd1000; rs2 = 32'd7; drem_unsigned = 1; valid = 1;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_ready_in_reset", 64'(ready), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!ready && cyc < 40);
        checkOutput("abort_restart_latency", 64'(cyc), 64'd33);
        checkOutput("abort_restart_result", {result_1, result_0}, 64'd142);
        flush = 1; @(posedge clock); #1;
        flush = 0; valid = 0; drem_unsigned = 0;
        clearInsn();

        for (int i = 0; i < 60; i++) begin
            int rop;
            rop = $urandom_range(0, 6);
            applyStimulus(rop, pickOperand(), pickOperand(), pickOperand(),
                          5'(1 << $urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0d", i, rop));
            if ($urandom_range(0, 3) == 0) begin
                repeat (2) @(posedge clock);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
